// File: rtl/mailbox_pkg.sv
// -----------------------------------------------------------------------------
// mailbox_pkg
// Definitions shared by the mailbox APB controller and its environment:
//   - state_t           : controller FSM states
//   - ADDR_*            : byte offsets of the control registers
//   - MSG_WINDOW_LIMIT  : first byte address past the message word window
//   - is_msg_addr()     : true for a word-aligned address inside the window
// -----------------------------------------------------------------------------
package mailbox_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MEM  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [7:0] ADDR_DOORBELL    = 8'h40;
  localparam logic [7:0] ADDR_STATUS      = 8'h44;
  localparam logic [7:0] ADDR_CLEAR       = 8'h48;
  localparam logic [7:0] ADDR_IRQ_EN      = 8'h4C;
  localparam logic [7:0] MSG_WINDOW_LIMIT = 8'h20;

  // Message words occupy 0x00..0x1C; byte-offset addresses are unmapped.
  function automatic logic is_msg_addr(input logic [7:0] addr);
    return (addr < MSG_WINDOW_LIMIT) && (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/mailbox_apb_ctrl.sv
// -----------------------------------------------------------------------------
// mailbox_apb_ctrl
// APB3 slave front end for a message mailbox. Message words (0x00-0x1C) are
// forwarded to an external store through a ready/valid side port; doorbell,
// status, clear and interrupt-enable registers live here.
//
// Ports
//   clk, resetn               : clock, asynchronous active-low reset
//   psel/penable/pwrite       : APB3 control
//   paddr[7:0], pwdata[31:0]  : APB3 address / write data
//   pready, pslverr, prdata   : APB3 response (valid only in the DONE cycle)
//   mbx_wr, mbx_wr_sel[2:0],
//   mbx_wdata[31:0]           : store write request, held until mbx_wr_ready
//   mbx_rd, mbx_rd_sel[3:0]   : store read request, held until mbx_rvalid
//   mbx_rdata[31:0]           : store read data, sampled with mbx_rvalid
//   irq                       : registered level interrupt, pending & irq_en
// -----------------------------------------------------------------------------
module mailbox_apb_ctrl
  import mailbox_pkg::*;
#(
  parameter int MESSAGE_DEPTH  = 1,
  parameter int TIMEOUT_CYCLES = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [7:0]  paddr,
  input  logic [31:0] pwdata,
  output logic        pready,
  output logic        pslverr,
  output logic [31:0] prdata,
  output logic        mbx_wr,
  output logic        mbx_rd,
  output logic [2:0]  mbx_wr_sel,
  output logic [3:0]  mbx_rd_sel,
  output logic [31:0] mbx_wdata,
  input  logic        mbx_wr_ready,
  input  logic        mbx_rvalid,
  input  logic [31:0] mbx_rdata,
  output logic        irq
);

  localparam int             CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [3:0]     DEPTH_L   = 4'(MESSAGE_DEPTH);

  state_t             r_state;
  logic               r_write;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_pready;
  logic               r_pslverr;
  logic [31:0]        r_prdata;
  logic               r_mbx_wr;
  logic               r_mbx_rd;
  logic [2:0]         r_wr_sel;
  logic [3:0]         r_rd_sel;
  logic [31:0]        r_wdata;
  logic               r_pending;
  logic               r_irq_en;
  logic               r_irq;

  logic               w_setup;
  logic               w_is_msg;
  logic               w_idx_ok;
  logic               w_reg_hit;
  logic [31:0]        w_reg_rdata;
  logic               w_handshake;
  logic [CNT_W-1:0]   w_cnt_inc;

  assign w_setup     = psel & ~penable;
  assign w_is_msg    = is_msg_addr(paddr);
  assign w_idx_ok    = {1'b0, paddr[4:2]} < DEPTH_L;
  assign w_handshake = r_write ? mbx_wr_ready : mbx_rvalid;
  assign w_cnt_inc   = r_cnt + 1'b1;

  // Register decode on the live setup-phase address; readable fields are
  // zero-extended, write-only registers read back as zero.
  always_comb begin
    w_reg_hit   = 1'b1;
    w_reg_rdata = '0;
    case (paddr)
      ADDR_DOORBELL: w_reg_rdata = '0;
      ADDR_STATUS:   w_reg_rdata = {30'd0, r_irq_en, r_pending};
      ADDR_CLEAR:    w_reg_rdata = '0;
      ADDR_IRQ_EN:   w_reg_rdata = {31'd0, r_irq_en};
      default:       w_reg_hit   = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= ST_IDLE;
      r_write   <= 1'b0;
      r_cnt     <= '0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      r_prdata  <= '0;
      r_mbx_wr  <= 1'b0;
      r_mbx_rd  <= 1'b0;
      r_wr_sel  <= '0;
      r_rd_sel  <= '0;
      r_wdata   <= '0;
      r_pending <= 1'b0;
      r_irq_en  <= 1'b0;
      r_irq     <= 1'b0;
    end else begin
      r_irq <= r_pending & r_irq_en;

      case (r_state)
        ST_IDLE: begin
          if (w_setup) begin
            r_write <= pwrite;
            r_cnt   <= '0;
            if (w_is_msg && w_idx_ok) begin
              // The request registers double as the latched address/data,
              // so later changes on the APB inputs cannot reach the store.
              r_state  <= ST_MEM;
              r_mbx_wr <= pwrite;
              r_mbx_rd <= ~pwrite;
              r_wr_sel <= pwrite ? paddr[4:2] : 3'd0;
              r_rd_sel <= pwrite ? 4'd0 : {1'b0, paddr[4:2]};
              r_wdata  <= pwrite ? pwdata : 32'd0;
            end else begin
              // Register access, out-of-range message index or unmapped
              // address: answer directly without touching the store.
              r_state   <= ST_DONE;
              r_pready  <= 1'b1;
              r_pslverr <= w_is_msg | ~w_reg_hit;
              r_prdata  <= (!pwrite && !w_is_msg) ? w_reg_rdata : 32'd0;
              if (pwrite && !w_is_msg) begin
                case (paddr)
                  ADDR_DOORBELL: r_pending <= 1'b1;
                  ADDR_CLEAR:    if (pwdata[0]) r_pending <= 1'b0;
                  ADDR_IRQ_EN:   r_irq_en <= pwdata[0];
                  default:       ;
                endcase
              end
            end
          end
        end

        ST_MEM: begin
          // A handshake in the last allowed cycle still wins over timeout.
          if (w_handshake || (w_cnt_inc == CNT_LIMIT)) begin
            r_state   <= ST_DONE;
            r_pready  <= 1'b1;
            r_pslverr <= ~w_handshake;
            r_prdata  <= (w_handshake && !r_write) ? mbx_rdata : 32'd0;
            r_mbx_wr  <= 1'b0;
            r_mbx_rd  <= 1'b0;
            r_wr_sel  <= '0;
            r_rd_sel  <= '0;
            r_wdata   <= '0;
            r_cnt     <= '0;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end

        ST_DONE: begin
          r_state   <= ST_IDLE;
          r_pready  <= 1'b0;
          r_pslverr <= 1'b0;
          r_prdata  <= '0;
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign pready     = r_pready;
  assign pslverr    = r_pslverr;
  assign prdata     = r_prdata;
  assign mbx_wr     = r_mbx_wr;
  assign mbx_rd     = r_mbx_rd;
  assign mbx_wr_sel = r_wr_sel;
  assign mbx_rd_sel = r_rd_sel;
  assign mbx_wdata  = r_wdata;
  assign irq        = r_irq;

endmodule

// File: tb/tb_mailbox_apb_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mailbox_apb_ctrl
// Drives APB transfers into mailbox_apb_ctrl, emulates the message store with
// a programmable response delay, and compares every response against a
// transaction-level model of the address map.
// -----------------------------------------------------------------------------
module tb_mailbox_apb_ctrl;

  localparam int DEPTH = 1;
  localparam int TMO   = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic        psel, penable, pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata;
  logic        pready, pslverr;
  logic [31:0] prdata;
  logic        mbx_wr, mbx_rd;
  logic [2:0]  mbx_wr_sel;
  logic [3:0]  mbx_rd_sel;
  logic [31:0] mbx_wdata;
  logic        mbx_wr_ready = 1'b0, mbx_rvalid = 1'b0;
  logic [31:0] mbx_rdata = '0;
  logic        irq;

  int vectors    = 0;
  int miscompares = 0;

  // Store emulation
  logic [31:0] store [8];
  int          store_stall = 0;   // cycles of delay before ready; <0 = never
  int          req_cnt     = 0;
  int          n_wr_cycles = 0;
  int          n_writes    = 0;
  logic [2:0]  last_wr_sel = 3'h7;

  // Reference model state
  logic [31:0] model_mem [8];
  bit          m_pend = 0;
  bit          m_en   = 0;

  mailbox_apb_ctrl #(.MESSAGE_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .resetn(resetn),
    .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata),
    .pready(pready), .pslverr(pslverr), .prdata(prdata),
    .mbx_wr(mbx_wr), .mbx_rd(mbx_rd),
    .mbx_wr_sel(mbx_wr_sel), .mbx_rd_sel(mbx_rd_sel), .mbx_wdata(mbx_wdata),
    .mbx_wr_ready(mbx_wr_ready), .mbx_rvalid(mbx_rvalid), .mbx_rdata(mbx_rdata),
    .irq(irq)
  );

  always #5 clk = ~clk;

  // Store responder: looks at the request mid-cycle and answers for the
  // coming rising edge. Read data is garbage unless rvalid is high.
  always @(negedge clk) begin
    bit rdy;
    if (mbx_wr || mbx_rd) begin
      req_cnt = req_cnt + 1;
      rdy = (store_stall >= 0) && (req_cnt > store_stall);
    end else begin
      req_cnt = 0;
      rdy = 1'b0;
    end
    mbx_wr_ready = rdy & mbx_wr;
    mbx_rvalid   = rdy & mbx_rd;
    mbx_rdata    = (rdy && mbx_rd) ? store[mbx_rd_sel[2:0]] : $urandom;
    if (mbx_wr) n_wr_cycles = n_wr_cycles + 1;
    if (mbx_wr && rdy) begin
      store[mbx_wr_sel] = mbx_wdata;
      n_writes    = n_writes + 1;
      last_wr_sel = mbx_wr_sel;
    end
  end

  function automatic logic [95:0] outs();
    return {20'd0, pready, pslverr, prdata, mbx_wr, mbx_rd, mbx_wr_sel,
            mbx_rd_sel, mbx_wdata, irq};
  endfunction

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Transaction-level model of the address map and store behaviour.
  task automatic model_xfer(input bit wr, input logic [7:0] a, input logic [31:0] d,
                            input int stall, output logic [31:0] rd, output logic err,
                            output int lat, output int wcyc, output int nwr);
    int idx;
    rd = '0; err = 1'b0; lat = 1; wcyc = 0; nwr = 0;
    if (a < 8'h20 && a[1:0] == 2'b00) begin
      idx = int'(a) / 4;
      if (idx >= DEPTH) begin
        err = 1'b1;
      end else if (stall >= 0 && stall < TMO) begin
        lat = stall + 2;
        if (wr) begin
          wcyc = stall + 1; nwr = 1; model_mem[idx] = d;
        end else begin
          rd = model_mem[idx];
        end
      end else begin
        lat = TMO + 1; err = 1'b1;
        if (wr) wcyc = TMO;
      end
    end else begin
      case (a)
        8'h40: if (wr) m_pend = 1;
        8'h44: if (!wr) rd = {30'd0, m_en, m_pend};
        8'h48: if (wr && d[0]) m_pend = 0;
        8'h4C: if (wr) m_en = d[0]; else rd = {31'd0, m_en};
        default: err = 1'b1;
      endcase
    end
  endtask

  task automatic apb_xfer(input bit wr, input logic [7:0] a, input logic [31:0] d,
                          input int stall, input bit glitch);
    logic [31:0] erd, grd;
    logic        eerr, gerr, g_irq_done;
    int          elat, ewc, enw, lat, wc0, nw0;
    bit          irq_old, irq_new, seen, stray;
    irq_old = m_pend & m_en;
    model_xfer(wr, a, d, stall, erd, eerr, elat, ewc, enw);
    irq_new = m_pend & m_en;
    store_stall = stall;
    wc0 = n_wr_cycles; nw0 = n_writes;
    grd = 'x; gerr = 'x; g_irq_done = 'x;

    @(negedge clk);
    psel = 1; penable = 0; pwrite = wr; paddr = a; pwdata = d;
    @(negedge clk);
    // Access phase: scramble the other inputs, they must have been latched.
    penable = 1; paddr = 8'($urandom); pwdata = $urandom; pwrite = ~wr;
    lat = 0; seen = 0; stray = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (k > 0) @(negedge clk);
      lat++;
      if (pready) begin
        seen = 1; grd = prdata; gerr = pslverr; g_irq_done = irq;
      end else begin
        if (pslverr) stray = 1;
        if (glitch && k == 1) begin
          penable = 0; paddr = 8'h40; pwrite = 1;   // stray setup phase
        end else begin
          penable = 1;
        end
      end
    end
    @(posedge clk); #1;
    psel = 0; penable = 0;

    check("latency",       96'(lat), 96'(elat));
    check("prdata",        96'(grd), 96'(erd));
    check("pslverr",       96'(gerr), 96'(eerr));
    check("pslverr_early", 96'(stray), 96'd0);
    check("wr_cycles",     96'(n_wr_cycles - wc0), 96'(ewc));
    check("store_writes",  96'(n_writes - nw0), 96'(enw));
    check("irq_in_done",   96'(g_irq_done), 96'(irq_old));
    check("irq_after",     96'(irq), 96'(irq_new));
    $display("xfer %s a=%02h d=%08h stall=%0d glitch=%0d -> rdata=%08h err=%0b lat=%0d irq=%0b",
             wr ? "WR" : "RD", a, d, stall, glitch, grd, gerr, lat, irq);
  endtask

  logic [7:0] addr_pool [12] = '{8'h00, 8'h00, 8'h04, 8'h1C, 8'h40, 8'h44,
                                 8'h48, 8'h4C, 8'h50, 8'h20, 8'h02, 8'h4C};
  int         stall_pool [8] = '{0, 0, 0, 1, 2, 3, 4, -1};

  initial begin
    int wc_r, nw_r;
    for (int i = 0; i < 8; i++) begin
      store[i] = '0;
      model_mem[i] = '0;
    end
    resetn = 0; psel = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0;
    repeat (2) @(negedge clk);
    check("reset_outputs", outs(), 96'd0);
    resetn = 1;
    @(negedge clk);
    check("idle_after_reset", outs(), 96'd0);

    // Basic write/read of message word 0
    apb_xfer(1, 8'h00, 32'hDEADBEEF, 0, 0);
    check("wr_sel", 96'(last_wr_sel), 96'd0);
    apb_xfer(0, 8'h00, 32'h0, 0, 0);
    // Index beyond depth, timeouts, stalled read with stray setup
    apb_xfer(1, 8'h04, 32'h11111111, 0, 0);
    apb_xfer(0, 8'h00, 32'h0, -1, 0);
    apb_xfer(1, 8'h00, 32'hCAFEF00D, 4, 0);
    apb_xfer(0, 8'h00, 32'h0, 2, 1);
    apb_xfer(1, 8'h00, 32'h01234567, 3, 1);
    apb_xfer(0, 8'h00, 32'h0, 3, 0);
    // Doorbell / interrupt sequence
    apb_xfer(1, 8'h4C, 32'h1, 0, 0);
    apb_xfer(1, 8'h40, 32'h1, 0, 0);
    apb_xfer(0, 8'h44, 32'h0, 0, 0);
    apb_xfer(1, 8'h40, 32'h0, 0, 0);
    apb_xfer(1, 8'h48, 32'h1, 0, 0);
    apb_xfer(0, 8'h44, 32'h0, 0, 0);
    apb_xfer(1, 8'h48, 32'h1, 0, 0);
    apb_xfer(0, 8'h40, 32'h0, 0, 0);
    apb_xfer(0, 8'h4C, 32'h0, 0, 0);
    apb_xfer(0, 8'h50, 32'h0, 0, 0);
    apb_xfer(1, 8'h02, 32'h5, 0, 0);

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      apb_xfer(1'($urandom), addr_pool[$urandom_range(0, 11)], $urandom,
               stall_pool[$urandom_range(0, 7)], ($urandom_range(0, 3) == 0));
    end

    // Reset in the middle of a store write that never completes
    apb_xfer(1, 8'h4C, 32'h1, 0, 0);
    apb_xfer(1, 8'h40, 32'h1, 0, 0);
    store_stall = -1;
    nw_r = n_writes;
    @(negedge clk);
    psel = 1; penable = 0; pwrite = 1; paddr = 8'h00; pwdata = 32'h12345678;
    @(negedge clk);
    penable = 1;
    #2 resetn = 0;
    #1 check("async_reset_outputs", outs(), 96'd0);
    @(negedge clk);
    psel = 0; penable = 0;
    wc_r = n_wr_cycles;
    repeat (2) @(negedge clk);
    resetn = 1;
    m_pend = 0; m_en = 0;
    repeat (3) @(negedge clk);
    check("no_wr_after_reset", 96'(n_wr_cycles - wc_r), 96'd0);
    check("aborted_write", 96'(n_writes - nw_r), 96'd0);
    apb_xfer(0, 8'h00, 32'h0, 0, 0);
    apb_xfer(0, 8'h44, 32'h0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
